// File: rtl/fsk_iq_modulator_if.sv
// Symbol input handshake and I/Q sample output bundle for the CPFSK modulator.
interface fsk_iq_modulator_if;
   logic [1:0]         mode;
   logic [3:0]         sym_data;
   logic               sym_valid;
   logic               sym_ready;
   logic signed [16:0] out_i;
   logic signed [16:0] out_q;
   logic               out_valid;
   logic               sym_start;

   modport master (
      output mode, sym_data, sym_valid,
      input  sym_ready, out_i, out_q, out_valid, sym_start
   );

   modport slave (
      input  mode, sym_data, sym_valid,
      output sym_ready, out_i, out_q, out_valid, sym_start
   );
endinterface

// File: rtl/fsk_iq_modulator.sv
// M-ary continuous-phase FSK modulator: one complex baseband sample per clock,
// phase carried across back-to-back symbols, idle (zero output) on underrun.
module fsk_iq_modulator #(
   parameter int SPS       = 64,
   parameter int PHASE_W   = 16,
   parameter int TONE_STEP = 128,
   parameter int AMP       = 16000
) (
   input  logic               clk,
   input  logic               rst,
   fsk_iq_modulator_if.slave  bus
);
   localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam longint PI_Q28 = 64'sd843314857;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // Elaboration-time round(AMP*sin(pi*j/128)) for j in 0..64, fixed-point Taylor series.
   function automatic longint quarter_sin(input longint j);
      longint x, x2, term, sum;
      x    = (PI_Q28 * j) / 64'sd128;
      x2   = (x * x) >>> 28;
      term = x;
      sum  = x;
      for (longint n = 1; n <= 8; n++) begin
         term = -((term * x2) >>> 28) / ((64'sd2 * n) * (64'sd2 * n + 64'sd1));
         sum  = sum + term;
      end
      return (sum * longint'(AMP) + (64'sd1 <<< 27)) >>> 28;
   endfunction

   function automatic logic signed [16:0] sin_entry(input longint i);
      longint q, j, mag;
      q   = i / 64'sd64;
      j   = i % 64'sd64;
      mag = (q == 64'sd1 || q == 64'sd3) ? quarter_sin(64'sd64 - j) : quarter_sin(j);
      return 17'((q >= 64'sd2) ? -mag : mag);
   endfunction

   logic signed [16:0] w_sin_lut [256];

   for (genvar g = 0; g < 256; g++) begin : g_lut
      localparam logic signed [16:0] LUT_VAL = sin_entry(longint'(g));
      assign w_sin_lut[g] = LUT_VAL;
   end

   state_t               r_state, w_state_nxt;
   logic [PHASE_W-1:0]   r_phase, w_phase_nxt;
   logic [PHASE_W-1:0]   r_inc, w_inc_nxt, w_inc_new;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic signed [16:0]   r_out_i, r_out_q;
   logic                 r_valid, r_start;
   logic                 w_emit, w_start_nxt;
   logic                 w_last, w_ready, w_accept;
   logic [4:0]           w_m;
   logic [3:0]           w_k;
   logic signed [5:0]    w_tone;
   logic signed [31:0]   w_tone_ext;
   logic [7:0]           w_idx, w_cos_idx;

   assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(SPS - 1));
   assign w_ready  = (r_state == S_IDLE) || w_last;
   assign w_accept = bus.sym_valid && w_ready;

   // Tone offset 2k+1-M is odd and symmetric about zero, so tones straddle DC.
   assign w_m        = 5'd2 << bus.mode;
   assign w_k        = bus.sym_data & w_m[3:0] - 4'd1;
   assign w_tone     = $signed({1'b0, w_k, 1'b1}) - $signed({1'b0, w_m});
   assign w_tone_ext = 32'(w_tone);
   assign w_inc_new  = PHASE_W'(w_tone_ext * TONE_STEP);

   assign w_idx     = r_phase[PHASE_W-1 -: 8];
   assign w_cos_idx = w_idx + 8'd64;

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_inc_nxt   = r_inc;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_start_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_RUN;
               w_inc_nxt   = w_inc_new;
               w_cnt_nxt   = '0;
               w_emit      = 1'b1;
               w_start_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               w_inc_nxt   = w_inc_new;
               w_cnt_nxt   = '0;
               w_emit      = 1'b1;
               w_start_nxt = 1'b1;
            end else if (w_last) begin
               w_state_nxt = S_IDLE;
               w_phase_nxt = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               w_emit    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A new symbol's first sample uses the carried phase; its own step applies after it.
      if (w_emit) w_phase_nxt = r_phase + w_inc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_inc   <= '0;
         r_cnt   <= '0;
         r_out_i <= '0;
         r_out_q <= '0;
         r_valid <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_inc   <= w_inc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_emit;
         r_start <= w_start_nxt;
         r_out_i <= w_emit ? w_sin_lut[w_cos_idx] : '0;
         r_out_q <= w_emit ? w_sin_lut[w_idx]     : '0;
      end
   end

   assign bus.sym_ready = w_ready;
   assign bus.out_i     = r_out_i;
   assign bus.out_q     = r_out_q;
   assign bus.out_valid = r_valid;
   assign bus.sym_start = r_start;

endmodule

// File: tb/tb_fsk_iq_modulator.sv
// Scoreboard bench: a phase-accumulator reference model queues expected samples
// at acceptance; a monitor compares every output cycle against the queue.
module tb_fsk_iq_modulator;
   localparam int SPS  = 64;
   localparam int STEP = 128;
   localparam int AMP  = 16000;

   typedef struct {
      int i;
      int q;
      bit st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   exp_t sb[$];
   bit   m_ready = 1'b1;

   fsk_iq_modulator_if bus();

   fsk_iq_modulator #(.SPS(SPS), .PHASE_W(16), .TONE_STEP(STEP), .AMP(AMP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: sample s of a symbol sits at phase base + s*inc (mod 2^16).
   initial begin
      bit running = 1'b0;
      int left = 0, base = 0, cur_inc = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            sb.delete();
            running = 1'b0;
            left    = 0;
         end else if (bus.sym_valid && m_ready) begin
            int m, k, inc;
            m   = 2 << int'(bus.mode);
            k   = int'(bus.sym_data) % m;
            inc = (2 * k + 1 - m) * STEP;
            base = running ? ((base + SPS * cur_inc) & 32'hFFFF) : 0;
            cur_inc = inc;
            for (int s = 0; s < SPS; s++) begin
               int   ph, idx;
               real  ang;
               exp_t e;
               ph    = (base + s * inc) & 32'hFFFF;
               idx   = ph >> 8;
               ang   = 2.0 * 3.14159265358979323846 * real'(idx) / 256.0;
               e.i   = rnd(real'(AMP) * $cos(ang));
               e.q   = rnd(real'(AMP) * $sin(ang));
               e.st  = (s == 0);
               sb.push_back(e);
            end
            left    = SPS - 1;
            running = 1'b1;
         end else if (running) begin
            if (left == 0) running = 1'b0;
            else left--;
         end
         m_ready = !running || (left == 0);
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         chk("sym_ready", int'(bus.sym_ready), int'(m_ready));
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_sample", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_i", int'(bus.out_i), e.i);
               chk("out_q", int'(bus.out_q), e.q);
               chk("sym_start", int'(bus.sym_start), int'(e.st));
            end
         end else begin
            chk("idle_out_i", int'(bus.out_i), 0);
            chk("idle_out_q", int'(bus.out_q), 0);
            chk("idle_start", int'(bus.sym_start), 0);
            chk("missing_sample", sb.size(), 0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a symbol until accepted; afterwards mode/data are scrambled to prove they are ignored.
   task automatic send(input logic [1:0] m, input logic [3:0] d, input bit keep);
      bit got = 1'b0;
      bus.mode      = m;
      bus.sym_data  = d;
      bus.sym_valid = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         got = bus.sym_ready && !rst;
         @(posedge clk);
         #1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      if (!keep) bus.sym_valid = 1'b0;
      bus.mode     = 2'($urandom);
      bus.sym_data = 4'($urandom);
   endtask

   initial begin
      bus.mode      = 2'd0;
      bus.sym_data  = 4'd0;
      bus.sym_valid = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(2);

      send(2'd0, 4'd1, 1'b0);  idle(70);
      send(2'd0, 4'd0, 1'b0);  idle(70);
      send(2'd1, 4'hF, 1'b0);  idle(70);
      send(2'd3, 4'd0, 1'b0);  idle(70);

      send(2'd2, 4'd5, 1'b1);
      send(2'd3, 4'd9, 1'b1);
      send(2'd0, 4'd1, 1'b0);
      idle(70);

      // Valid raised mid-symbol must wait for the last sample, then a 5-cycle gap.
      send(2'd1, 4'd2, 1'b0);
      idle(10);
      send(2'd2, 4'd3, 1'b0);
      idle(SPS + 4);
      send(2'd3, 4'd11, 1'b0);
      idle(70);

      send(2'd3, 4'd7, 1'b0);
      idle(20);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      send(2'd0, 4'd1, 1'b0);
      idle(70);

      for (int n = 0; n < 40; n++) begin
         bit keep;
         keep = 1'($urandom);
         send(2'($urandom), 4'($urandom), keep);
         if (!keep) idle(int'($urandom_range(0, 70)));
      end
      bus.sym_valid = 1'b0;
      idle(80);
      chk("drain", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
